// File: rtl/dual_port_ram_16x8.sv
// True dual-port RAM, 16x8 default, both ports read-first; 1-cycle read latency, no backpressure (accepts every edge).
// Optional COLLISION_FLAG_EN adds a registered same-address double-write flag; port A wins such collisions in all builds.
// Async active-low reset clears the whole array and both read registers.
module dual_port_ram_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] datain_a,
    input  logic [DATA_W-1:0] datain_b,
    input  logic              en_a,
    input  logic              en_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b
`ifdef COLLISION_FLAG_EN
    ,
    output logic              collision
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout_a;
    logic [DATA_W-1:0] r_dout_b;

    // Per-word write select: A is checked first so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_dout_a <= '0;
            r_dout_b <= '0;
        end else begin
            r_dout_a <= r_mem[add_a];
            r_dout_b <= r_mem[add_b];
            for (int i = 0; i < DEPTH; i++) begin
                if (en_a && (add_a == ADDR_W'(i))) begin
                    r_mem[i] <= datain_a;
                end else if (en_b && (add_b == ADDR_W'(i))) begin
                    r_mem[i] <= datain_b;
                end
            end
        end
    end

    assign data_out_a = r_dout_a;
    assign data_out_b = r_dout_b;

`ifdef COLLISION_FLAG_EN
    logic w_collide;
    logic r_collision;

    assign w_collide = en_a && en_b && (add_a == add_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_collide;
        end
    end

    assign collision = r_collision;
`endif

endmodule

// File: tb/tb_dual_port_ram_16x8.sv
// Directed self-checking bench for dual_port_ram_16x8.
module tb_dual_port_ram_16x8;

    logic       clk;
    logic       rst_n;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [7:0] datain_a;
    logic [7:0] datain_b;
    logic       en_a;
    logic       en_b;
    logic [7:0] data_out_a;
    logic [7:0] data_out_b;
`ifdef COLLISION_FLAG_EN
    logic       collision;
`endif

    int errors = 0;
    int checks = 0;

    dual_port_ram_16x8 #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_a      (add_a),
        .add_b      (add_b),
        .datain_a   (datain_a),
        .datain_b   (datain_b),
        .en_a       (en_a),
        .en_b       (en_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
`ifdef COLLISION_FLAG_EN
        ,
        .collision  (collision)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        add_a    = 4'd0;
        add_b    = 4'd0;
        datain_a = 8'd0;
        datain_b = 8'd0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        #3;
        check("reset_a", data_out_a, 8'h00);
        check("reset_b", data_out_b, 8'h00);
`ifdef COLLISION_FLAG_EN
        check("reset_coll", {7'd0, collision}, 8'h00);
`endif
        #1;
        rst_n = 1'b1;

        // Pre-load addr 2 so the mid-run reset has something to clear
        en_a = 1'b1; add_a = 4'd2; datain_a = 8'h77; add_b = 4'd2;
        step();
        en_a = 1'b0;
        step();
        check("preload_a", data_out_a, 8'h77);
        check("preload_b", data_out_b, 8'h77);

        // Mid-run asynchronous reset, no clock edge needed
        rst_n = 1'b0;
        #1;
        check("midreset_a", data_out_a, 8'h00);
        check("midreset_b", data_out_b, 8'h00);
        #1;
        rst_n = 1'b1;
        add_a = 4'd2; add_b = 4'd3;
        step();
        check("post_reset_rd2", data_out_a, 8'h00);
        check("post_reset_rd3", data_out_b, 8'h00);

        // Parallel writes to different addresses
        en_a = 1'b1; add_a = 4'd2; datain_a = 8'd21;
        en_b = 1'b1; add_b = 4'd3; datain_b = 8'd34;
        step();
        check("par_wr_edge_a", data_out_a, 8'h00);
        check("par_wr_edge_b", data_out_b, 8'h00);
        en_a = 1'b0; en_b = 1'b0;
        step();
        check("par_rd_a", data_out_a, 8'd21);
        check("par_rd_b", data_out_b, 8'd34);

        // Same-address write collision, port A wins
        en_a = 1'b1; add_a = 4'd5; datain_a = 8'hAA;
        en_b = 1'b1; add_b = 4'd5; datain_b = 8'hBB;
        step();
`ifdef COLLISION_FLAG_EN
        check("coll_flag_hi", {7'd0, collision}, 8'h01);
`endif
        en_a = 1'b0; en_b = 1'b0;
        step();
        check("coll_rd_a", data_out_a, 8'hAA);
        check("coll_rd_b", data_out_b, 8'hAA);
`ifdef COLLISION_FLAG_EN
        check("coll_flag_lo", {7'd0, collision}, 8'h00);
`endif

        // Cross-port visibility
        en_a = 1'b1; add_a = 4'd9; datain_a = 8'd99; add_b = 4'd7;
        step();
        check("unwritten_7", data_out_b, 8'h00);
        en_a = 1'b0; add_a = 4'd8; add_b = 4'd9;
        step();
        check("unwritten_8", data_out_a, 8'h00);
        check("cross_rd_b", data_out_b, 8'd99);

        // B reads the address A writes on the same edge: old data
        en_a = 1'b1; add_a = 4'd9; datain_a = 8'd100;
        step();
        check("cross_same_edge_b", data_out_b, 8'd99);
        en_a = 1'b0;
        step();
        check("cross_next_edge_b", data_out_b, 8'd100);

        // Sequential overwrite A then B
        en_a = 1'b1; add_a = 4'd10; datain_a = 8'd111;
        step();
        en_a = 1'b0;
        en_b = 1'b1; add_b = 4'd10; datain_b = 8'd222;
        step();
        check("ovw_mid_a", data_out_a, 8'd111);
        en_b = 1'b0;
        step();
        check("ovw_rd_a", data_out_a, 8'd222);
        check("ovw_rd_b", data_out_b, 8'd222);
        add_a = 4'd2; add_b = 4'd3;
        step();
        check("reread_2", data_out_a, 8'd21);
        check("reread_3", data_out_b, 8'd34);

        // Read-first on the same port
        en_a = 1'b1; add_a = 4'd4; datain_a = 8'h55;
        step();
        check("rf_write_edge", data_out_a, 8'h00);
        en_a = 1'b0;
        step();
        check("rf_next_edge", data_out_a, 8'h55);
        #3;
        check("rf_hold", data_out_a, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
